// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter in front of a shared peripheral port.
// Allows one outstanding transaction at a time and has an optional response timeout.
module periph_bus_arbiter #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BE_WIDTH     = DATA_WIDTH/8,
  parameter int                    ID_WIDTH     = 10,
  parameter int                    TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_add_i,
  input  logic                  m0_wen_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [ID_WIDTH-1:0]   m0_id_i,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_add_i,
  input  logic                  m1_wen_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [ID_WIDTH-1:0]   m1_id_i,
  output logic                  m0_gnt_o,
  output logic                  m0_r_valid_o,
  output logic [DATA_WIDTH-1:0] m0_r_rdata_o,
  output logic [ID_WIDTH-1:0]   m0_r_id_o,
  output logic                  m0_r_err_o,
  output logic                  m1_gnt_o,
  output logic                  m1_r_valid_o,
  output logic [DATA_WIDTH-1:0] m1_r_rdata_o,
  output logic [ID_WIDTH-1:0]   m1_r_id_o,
  output logic                  m1_r_err_o,
  output logic                  s_req_o,
  output logic [ADDR_WIDTH-1:0] s_add_o,
  output logic                  s_wen_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  output logic [BE_WIDTH-1:0]   s_be_o,
  input  logic                  s_gnt_i,
  input  logic                  s_r_valid_i,
  input  logic [DATA_WIDTH-1:0] s_r_rdata_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                owner_q, owner_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                  any_req, winner;
  logic                  resp_vld, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  assign any_req = m0_req_i | m1_req_i;
  // rr_q only breaks ties; a lone requester always wins
  assign winner  = (m0_req_i & m1_req_i) ? rr_q : m1_req_i;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    s_req_o   = 1'b0;
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    m0_gnt_o  = 1'b0;
    m1_gnt_o  = 1'b0;
    busy_o    = 1'b0;
    timeout_o = 1'b0;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    // outputs are forced low for the whole time reset is held, not just at the edge
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          s_req_o   = any_req;
          s_add_o   = winner ? m1_add_i   : m0_add_i;
          s_wen_o   = winner ? m1_wen_i   : m0_wen_i;
          s_wdata_o = winner ? m1_wdata_i : m0_wdata_i;
          s_be_o    = winner ? m1_be_i    : m0_be_i;
          if (any_req && s_gnt_i) begin
            m0_gnt_o = ~winner;
            m1_gnt_o = winner;
            owner_d  = winner;
            id_d     = winner ? m1_id_i : m0_id_i;
            rr_d     = ~winner;
            cnt_d    = '0;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          busy_o = 1'b1;
          if (s_r_valid_i) begin
            resp_vld  = 1'b1;
            resp_data = s_r_rdata_i;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (TO_EN && cnt_q == CNT_LAST) begin
            resp_vld  = 1'b1;
            resp_err  = 1'b1;
            resp_data = TIMEOUT_DATA;
            timeout_o = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (TO_EN) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m0_r_valid_o = resp_vld & ~owner_q;
    m1_r_valid_o = resp_vld & owner_q;
    m0_r_err_o   = resp_err & ~owner_q;
    m1_r_err_o   = resp_err & owner_q;
    m0_r_rdata_o = m0_r_valid_o ? resp_data : '0;
    m1_r_rdata_o = m1_r_valid_o ? resp_data : '0;
    m0_r_id_o    = m0_r_valid_o ? id_q : '0;
    m1_r_id_o    = m1_r_valid_o ? id_q : '0;
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_periph_bus_arbiter;

  localparam int AW = 32, DW = 32, BW = 4, IW = 10, TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m1_req, m0_wen, m1_wen, s_gnt, s_r_valid;
  logic [AW-1:0] m0_add, m1_add, s_add;
  logic [DW-1:0] m0_wdata, m1_wdata, s_r_rdata, s_wdata, m0_r_rdata, m1_r_rdata;
  logic [BW-1:0] m0_be, m1_be, s_be;
  logic [IW-1:0] m0_id, m1_id, m0_r_id, m1_r_id;
  logic m0_gnt, m1_gnt, m0_r_valid, m1_r_valid, m0_r_err, m1_r_err;
  logic s_req, s_wen, busy, timeout;

  int checks = 0;
  int errors = 0;

  periph_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_add_i(m0_add), .m0_wen_i(m0_wen), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_id_i(m0_id),
    .m1_req_i(m1_req), .m1_add_i(m1_add), .m1_wen_i(m1_wen), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_id_i(m1_id),
    .m0_gnt_o(m0_gnt), .m0_r_valid_o(m0_r_valid), .m0_r_rdata_o(m0_r_rdata),
    .m0_r_id_o(m0_r_id), .m0_r_err_o(m0_r_err),
    .m1_gnt_o(m1_gnt), .m1_r_valid_o(m1_r_valid), .m1_r_rdata_o(m1_r_rdata),
    .m1_r_id_o(m1_r_id), .m1_r_err_o(m1_r_err),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_rdata_i(s_r_rdata),
    .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct { bit m; logic [IW-1:0] id; int age; } txn_t;
  typedef struct {
    logic g0, g1, v0, v1, e0, e1, sreq, swen, bsy, tmo;
    logic [DW-1:0] d0, d1, swd;
    logic [AW-1:0] sadd;
    logic [IW-1:0] i0, i1;
    logic [BW-1:0] sbe;
    bit bus_defined;
  } exp_t;

  txn_t pend[$];      // the single outstanding transaction, if any
  bit   last_gnt = 1; // master granted most recently; the other one is preferred on a tie
  exp_t ex;
  bit   do_grant, do_retire, w;

  task automatic model_eval();
    logic [DW-1:0] d;
    logic err;
    ex = '{default: '0};
    ex.bus_defined = 1'b1;
    do_grant = 0; do_retire = 0; w = 0;
    if (rst) return;
    if (pend.size() == 0) begin
      w = (m0_req && m1_req) ? !last_gnt : m1_req;
      ex.sreq = m0_req | m1_req;
      ex.bus_defined = ex.sreq;
      ex.sadd = w ? m1_add : m0_add;
      ex.swen = w ? m1_wen : m0_wen;
      ex.swd  = w ? m1_wdata : m0_wdata;
      ex.sbe  = w ? m1_be : m0_be;
      if (ex.sreq && s_gnt) begin
        do_grant = 1;
        if (w) ex.g1 = 1'b1; else ex.g0 = 1'b1;
      end
    end else begin
      ex.bsy = 1'b1;
      ex.bus_defined = 1'b0;
      if (s_r_valid || (TMO != 0 && pend[0].age + 1 == TMO)) begin
        do_retire = 1;
        err = !s_r_valid;
        d = s_r_valid ? s_r_rdata : 32'hDEAD_BEEF;
        ex.tmo = err;
        if (pend[0].m) begin ex.v1 = 1; ex.d1 = d; ex.i1 = pend[0].id; ex.e1 = err; end
        else           begin ex.v0 = 1; ex.d0 = d; ex.i0 = pend[0].id; ex.e0 = err; end
      end
    end
  endtask

  task automatic model_commit();
    txn_t t;
    if (rst) begin
      pend.delete();
      last_gnt = 1;
    end else if (do_grant) begin
      t.m = w; t.id = w ? m1_id : m0_id; t.age = 0;
      pend.push_back(t);
      last_gnt = w;
    end else if (do_retire) begin
      void'(pend.pop_front());
    end else if (pend.size() != 0) begin
      pend[0].age++;
    end
  endtask

  task automatic model_check(input string tag);
    chk($sformatf("%s.gnt", tag), {m1_gnt, m0_gnt}, {ex.g1, ex.g0});
    chk($sformatf("%s.rvalid", tag), {m1_r_valid, m0_r_valid}, {ex.v1, ex.v0});
    chk($sformatf("%s.rerr", tag), {m1_r_err, m0_r_err}, {ex.e1, ex.e0});
    chk($sformatf("%s.rdata0", tag), m0_r_rdata, ex.d0);
    chk($sformatf("%s.rdata1", tag), m1_r_rdata, ex.d1);
    chk($sformatf("%s.rid", tag), {m1_r_id, m0_r_id}, {ex.i1, ex.i0});
    chk($sformatf("%s.sreq_busy_to", tag), {s_req, busy, timeout}, {ex.sreq, ex.bsy, ex.tmo});
    if (ex.bus_defined) begin
      chk($sformatf("%s.sadd", tag), s_add, ex.sadd);
      chk($sformatf("%s.swen_be", tag), {s_wen, s_be}, {ex.swen, ex.sbe});
      chk($sformatf("%s.swdata", tag), s_wdata, ex.swd);
    end
  endtask

  // inputs are set right after a falling edge; outputs are sampled 1 time unit later
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cyc(input string tag);
    #1;
    model_eval();
    model_check(tag);
    model_commit();
  endtask

  task automatic base();
    rst = 0; m0_req = 0; m1_req = 0; s_gnt = 0; s_r_valid = 0; s_r_rdata = '0;
    m0_add = 32'h0000_0100; m1_add = 32'h0000_0200;
    m0_wen = 1'b1; m1_wen = 1'b0;
    m0_wdata = 32'h0A0A_0A0A; m1_wdata = 32'h0B0B_0B0B;
    m0_be = 4'hF; m1_be = 4'h3;
    m0_id = 10'h015; m1_id = 10'h02A;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, r0, r1, gnt, rv;
    logic [DW-1:0] rdata;
    logic g0, g1, v0, v1, err, bsy;
    logic [DW-1:0] rd;
    logic [IW-1:0] rid;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rs, r0, r1, gn, rv, input logic [DW-1:0] rdata,
                              input logic g0, g1, v0, v1, er, bs,
                              input logic [DW-1:0] rd, input logic [IW-1:0] rid);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.gnt = gn; v.rv = rv; v.rdata = rdata;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.err = er; v.bsy = bs; v.rd = rd; v.rid = rid;
    return v;
  endfunction

  initial begin
    base();
    rst = 1;

    //           rst r0 r1 gnt rv rdata         g0 g1 v0 v1 err bsy rd            rid
    vt.push_back(mk(1, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 0, 1, 0, 32'h0,       1, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 1, 32'h0,       10'h0));
    vt.push_back(mk(0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 1, 32'h0,       10'h0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h1234,    0, 0, 1, 0, 0, 1, 32'h1234,    10'h015));
    vt.push_back(mk(0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(1, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 1, 1, 0, 32'h0,       1, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 1, 1, 1, 32'hA0,      0, 0, 1, 0, 0, 1, 32'hA0,      10'h015));
    vt.push_back(mk(0, 1, 1, 1, 0, 32'h0,       0, 1, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 1, 1, 1, 32'hA1,      0, 0, 0, 1, 0, 1, 32'hA1,      10'h02A));
    vt.push_back(mk(0, 1, 1, 1, 0, 32'h0,       1, 0, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 1, 1, 1, 32'hA2,      0, 0, 1, 0, 0, 1, 32'hA2,      10'h015));
    vt.push_back(mk(0, 1, 1, 1, 0, 32'h0,       0, 1, 0, 0, 0, 0, 32'h0,       10'h0));
    vt.push_back(mk(0, 1, 1, 1, 1, 32'hA3,      0, 0, 0, 1, 0, 1, 32'hA3,      10'h02A));

    foreach (vt[i]) begin
      nxt();
      base();
      rst = vt[i].rst; m0_req = vt[i].r0; m1_req = vt[i].r1;
      s_gnt = vt[i].gnt; s_r_valid = vt[i].rv; s_r_rdata = vt[i].rdata;
      cyc($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.gnt", i), {m1_gnt, m0_gnt}, {vt[i].g1, vt[i].g0});
      chk($sformatf("vec%0d.rvalid", i), {m1_r_valid, m0_r_valid}, {vt[i].v1, vt[i].v0});
      chk($sformatf("vec%0d.err", i), m0_r_err | m1_r_err, vt[i].err);
      chk($sformatf("vec%0d.busy", i), busy, vt[i].bsy);
      chk($sformatf("vec%0d.rdata", i), vt[i].v1 ? m1_r_rdata : m0_r_rdata, vt[i].rd);
      chk($sformatf("vec%0d.rid", i), vt[i].v1 ? m1_r_id : m0_r_id, vt[i].rid);
      if (vt[i].g0) chk($sformatf("vec%0d.sadd", i), {s_add, s_wen}, {32'h100, 1'b1});
      if (vt[i].g1) chk($sformatf("vec%0d.sadd", i), {s_add, s_wen}, {32'h200, 1'b0});
    end

    // grant stall: the selected winner must hold while s_gnt is low
    nxt(); base(); rst = 1; cyc("stall_rst");
    for (int k = 0; k < 4; k++) begin
      nxt(); base(); m0_req = 1; m1_req = 1; m0_add = 32'hCAFE_0000; m1_add = 32'hBEEF_0000;
      cyc("stall");
      chk("stall.sadd", s_add, 32'hCAFE_0000);
      chk("stall.gnt", {m1_gnt, m0_gnt, s_req}, 3'b001);
    end
    nxt(); base(); m0_req = 1; m1_req = 1; s_gnt = 1; cyc("stall_gnt");
    chk("stall_gnt.gnt", {m1_gnt, m0_gnt}, 2'b01);
    nxt(); base(); s_r_valid = 1; s_r_rdata = 32'h77; cyc("stall_rsp");

    // timeout on m1, then a late response is dropped
    nxt(); base(); m1_req = 1; s_gnt = 1; cyc("to_gnt");
    chk("to_gnt.gnt", m1_gnt, 1'b1);
    for (int k = 0; k < TMO; k++) begin
      nxt(); base(); cyc("to_wait");
      chk($sformatf("to_wait%0d.valid", k), {m1_r_valid, m0_r_valid}, {(k == TMO-1), 1'b0});
      chk($sformatf("to_wait%0d.rdata", k), m1_r_rdata, (k == TMO-1) ? 32'hDEAD_BEEF : 32'h0);
      chk($sformatf("to_wait%0d.err_to", k), {m1_r_err, timeout}, {2{(k == TMO-1)}});
    end
    nxt(); base(); s_r_valid = 1; s_r_rdata = 32'h5555; cyc("late");
    chk("late.valid", {m1_r_valid, m0_r_valid, busy}, 3'b000);

    // real response on the last timeout cycle wins
    nxt(); base(); m0_req = 1; s_gnt = 1; cyc("race_gnt");
    chk("race_gnt.gnt", m0_gnt, 1'b1);
    for (int k = 0; k < TMO; k++) begin
      nxt(); base();
      if (k == TMO-1) begin s_r_valid = 1; s_r_rdata = 32'hCAFE; end
      cyc("race_wait");
      chk($sformatf("race%0d.valid", k), m0_r_valid, (k == TMO-1));
      chk($sformatf("race%0d.err_to", k), {m0_r_err, timeout}, 2'b00);
    end
    chk("race.rdata_last", m0_r_rdata, 32'hCAFE);

    // reset in the middle of a transaction
    nxt(); base(); m0_req = 1; s_gnt = 1; cyc("rst_gnt");
    nxt(); base(); cyc("rst_busy");
    nxt(); base(); cyc("rst_busy");
    chk("rst_busy.busy", busy, 1'b1);
    nxt(); base(); rst = 1; m0_req = 1; m1_req = 1; s_gnt = 1; s_r_valid = 1; s_r_rdata = 32'h99;
    cyc("rst_mid");
    chk("rst_mid.outs", {s_req, busy, m0_gnt, m1_gnt, m0_r_valid, m1_r_valid, timeout}, 7'b0);
    chk("rst_mid.sadd", s_add, 32'h0);
    nxt(); base(); rst = 1; cyc("rst_hold");
    nxt(); base(); s_r_valid = 1; s_r_rdata = 32'h98; cyc("rst_late");
    chk("rst_late.valid", {m1_r_valid, m0_r_valid}, 2'b00);
    nxt(); base(); m0_req = 1; m1_req = 1; s_gnt = 1; cyc("rst_first");
    chk("rst_first.gnt", {m1_gnt, m0_gnt}, 2'b01);
    nxt(); base(); s_r_valid = 1; cyc("rst_done");

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      nxt();
      rst = ($urandom_range(0, 99) == 0);
      m0_req = 1'($urandom_range(0, 1)); m1_req = 1'($urandom_range(0, 1));
      m0_add = $urandom; m1_add = $urandom;
      m0_wen = 1'($urandom_range(0, 1)); m1_wen = 1'($urandom_range(0, 1));
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_be = 4'($urandom); m1_be = 4'($urandom);
      m0_id = 10'($urandom); m1_id = 10'($urandom);
      s_gnt = 1'($urandom_range(0, 1));
      s_r_valid = ($urandom_range(0, 2) == 0);
      s_r_rdata = $urandom;
      cyc($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the request address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the write and read data width.
REQ-003 The block SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, meaning the byte-enable width.
REQ-004 The block SHALL have parameter ID_WIDTH, default 10, meaning the transaction ID width.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the response timeout in cycles (0 = disabled, max 65535).
REQ-006 The block SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_BEEF, meaning the read data returned on timeout.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-009 The block SHALL have ports m0_req_i / m1_req_i, input, 1 bit each: master request.
REQ-010 The block SHALL have ports m0_add_i / m1_add_i, input, ADDR_WIDTH each: master address.
REQ-011 The block SHALL have ports m0_wen_i / m1_wen_i, input, 1 bit each: write enable, active-low (0 = write).
REQ-012 The block SHALL have ports m0_wdata_i / m1_wdata_i, input, DATA_WIDTH each: master write data.
REQ-013 The block SHALL have ports m0_be_i / m1_be_i, input, BE_WIDTH each: master byte enables.
REQ-014 The block SHALL have ports m0_id_i / m1_id_i, input, ID_WIDTH each: master transaction ID.
REQ-015 The block SHALL have ports m0_gnt_o / m1_gnt_o, output, 1 bit each: grant to the master.
REQ-016 The block SHALL have ports m0_r_valid_o / m1_r_valid_o, output, 1 bit each: response valid to the master.
REQ-017 The block SHALL have ports m0_r_rdata_o / m1_r_rdata_o, output, DATA_WIDTH each: response read data.
REQ-018 The block SHALL have ports m0_r_id_o / m1_r_id_o, output, ID_WIDTH each: response ID.
REQ-019 The block SHALL have ports m0_r_err_o / m1_r_err_o, output, 1 bit each: response error (timeout).
REQ-020 The block SHALL have ports s_req_o, s_add_o, s_wen_o, s_wdata_o and s_be_o, outputs (1, ADDR_WIDTH, 1, DATA_WIDTH, BE_WIDTH bits): the request to the shared peripheral demux.
REQ-021 The block SHALL have ports s_gnt_i, s_r_valid_i and s_r_rdata_i, inputs (1, 1, DATA_WIDTH bits): grant and response from the demux.
REQ-022 The block SHALL have port busy_o, output, 1 bit: high while a transaction is outstanding.
REQ-023 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a timeout response is issued.

Function
REQ-024 The block SHALL implement a state machine with states IDLE and BUSY, and SHALL allow at most one outstanding transaction.
REQ-025 In IDLE, the winner SHALL be the requesting master; if both request, the winner SHALL be the master indicated by the round-robin pointer rr_q.
REQ-026 In IDLE, the winner's add/wen/wdata/be SHALL drive s_* combinationally, and s_req_o SHALL equal the OR of the master requests.
REQ-027 In IDLE, when s_gnt_i=1, the block SHALL, in the same cycle:
- assert the winner's gnt_o;
- register the owner and the owner's id_i;
- set rr_q to the non-winner;
- enter BUSY.
REQ-028 When s_gnt_i=0, rr_q SHALL NOT change, so the selected winner stays stable while it keeps requesting.
REQ-029 In BUSY:
- s_req_o and all gnt_o SHALL be 0;
- busy_o SHALL be 1;
- cnt_q (16-bit) SHALL increment each cycle from 0.
REQ-030 In BUSY, when s_r_valid_i=1, the block SHALL, in the same cycle:
- drive owner r_valid_o=1, r_rdata_o=s_r_rdata_i, r_id_o=the registered ID, r_err_o=0;
- return to IDLE and clear cnt_q.
REQ-031 In BUSY, when TIMEOUT≠0 and cnt_q==TIMEOUT-1 without s_r_valid_i, the block SHALL:
- drive owner r_valid_o=1, r_rdata_o=TIMEOUT_DATA, r_err_o=1;
- pulse timeout_o;
- return to IDLE.
REQ-032 If s_r_valid_i coincides with the timeout cycle, the real response SHALL win (r_err_o=0, no timeout_o).
REQ-033 s_r_valid_i in IDLE (late response after a timeout, or spurious) SHALL be discarded, with no r_valid_o to any master.
REQ-034 A grant in IDLE SHALL NOT coincide with a response to the same transaction; the earliest response SHALL be the cycle after the grant.
REQ-035 The non-owner's r_valid_o, r_err_o and gnt_o SHALL be 0 at all times.
REQ-036 r_rdata_o and r_id_o SHALL be 0 whenever the corresponding r_valid_o is 0.
REQ-037 When TIMEOUT=0, cnt_q SHALL be held at 0 and the block SHALL wait in BUSY indefinitely.

Reset
REQ-038 While rst_i=1, asynchronously, the block SHALL set state=IDLE, rr_q=m0, cnt_q=0, owner=m0 and registered ID=0.
REQ-039 While rst_i=1, every output SHALL be 0.
REQ-040 Reset asserted during BUSY SHALL abandon the transaction with no response.
REQ-041 After reset releases, any pending s_r_valid_i SHALL be discarded per REQ-033.

Verification
REQ-042 The bench SHALL cover: m0 read, id=0x15, s_gnt_i immediate, s_r_valid_i 3 cycles later with rdata 0x1234 -> m0_gnt_o in the request cycle; m0_r_valid_o=1, rdata 0x1234, r_id 0x15, err 0; busy_o high for 3 cycles.
REQ-043 The bench SHALL cover: m0 and m1 requesting continuously, one-cycle responses -> grants alternate m0, m1, m0, m1.
REQ-044 The bench SHALL cover: both requesting, s_gnt_i low for 4 cycles -> s_add_o stable at m0_add_i throughout, no gnt_o, rr_q unchanged.
REQ-045 The bench SHALL cover: TIMEOUT=8, no s_r_valid_i -> 8th BUSY cycle m1_r_valid_o=1, rdata 0xDEADBEEF, err 1, timeout_o pulse; a later s_r_valid_i is dropped.
REQ-046 The bench SHALL cover: s_r_valid_i on the cycle where cnt_q==TIMEOUT-1 -> real data returned, err 0, no timeout_o.
REQ-047 The bench SHALL cover: rst_i asserted mid-BUSY -> all outputs 0 immediately; after release, the first grant goes to m0 when both masters request.
